// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential integer divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   div_state_e : FSM encoding DIV_IDLE / DIV_CALC / DIV_FIX / DIV_DONE
//   DIV_STEPS   : number of restoring iterations (one per quotient bit)
//   DIV_TAG_W   : default width of the opaque tag carried with each op
//   div_abs()   : magnitude of an operand, identity for unsigned ops
package div_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  localparam int DIV_STEPS = 32;
  localparam int DIV_TAG_W = 5;

  // |0x8000_0000| wraps back to 0x8000_0000, which is the correct 32-bit
  // unsigned magnitude, so no widening is needed.
  function automatic logic [31:0] div_abs(input logic [31:0] v, input logic uns);
    return (!uns && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the issue stage and the sequential divider.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
//
// Signals:
//   flush                  kill any in-flight op
//   in_valid / in_ready    request handshake
//   is_unsigned, use_mod   op selectors (div/mod, signed/unsigned)
//   dividend, divisor      operands, sampled only at accept
//   in_tag / out_tag       opaque tag travelling with the op
//   out_valid / out_ready  result handshake
//   result                 quotient or remainder
//   busy                   divider is not idle
interface div_seq_ctrl_if
  import div_seq_ctrl_pkg::*;
#(
  parameter int TAG_W = DIV_TAG_W
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             is_unsigned;
  logic             use_mod;
  logic [31:0]      dividend;
  logic [31:0]      divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  // Issue/writeback side.
  modport master (
    output flush, in_valid, is_unsigned, use_mod, dividend, divisor, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );

  // Divider side.
  modport slave (
    input  flush, in_valid, is_unsigned, use_mod, dividend, divisor, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );

endinterface

// File: rtl/div_seq_ctrl_restore_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract d, keep if no borrow.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   r_i, q_i, d_i : partial remainder, dividend/quotient shift register, divisor magnitude
//   r_o, q_o      : updated partial remainder and quotient register
module div_restore_step (
  input  logic [31:0] r_i,
  input  logic [31:0] q_i,
  input  logic [31:0] d_i,
  output logic [31:0] r_o,
  output logic [31:0] q_o
);

  logic [32:0] r_sh;
  logic [33:0] trial;
  logic        borrow;

  // Remainder picks up the next dividend bit from the top of q; it can reach
  // 33 bits before the subtract, so the trial runs at 33 bits plus borrow.
  assign r_sh   = {r_i, q_i[31]};
  assign trial  = {1'b0, r_sh} - {2'b00, d_i};
  assign borrow = trial[33];

  // After a successful subtract the remainder is < d, so it fits in 32 bits.
  assign r_o = borrow ? r_sh[31:0] : trial[31:0];
  assign q_o = {q_i[30:0], ~borrow};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider for div.w/mod.w/div.wu/mod.wu with sign fix, div-by-zero and flush.
// Latency: result valid 34 cycles after accept (2 cycles for divide-by-zero or early-out).
// Backpressure: one op in flight; in_ready low until the result is taken with out_ready.
//
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-low reset
//   bus    div_seq_ctrl_if.slave (request, result and flush signals)
// Build option:
//   DIV_EARLY_OUT_EN  when defined, an op with |divisor| > |dividend| skips the
//                     32 iterations (q=0, r=|dividend|); results are unchanged.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic          clk,
  input  logic          reset,
  div_seq_ctrl_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [4:0]       cnt_q;
  logic [31:0]      r_q, q_q, d_q;
  logic             neg_q_q, neg_r_q, mod_q, dz_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             accept;
  logic [31:0]      abs_a, abs_b;
  logic             div_zero, early;
  logic [31:0]      r_nxt, q_nxt;
  logic [31:0]      q_fix, r_fix;

  assign abs_a    = div_abs(bus.dividend, bus.is_unsigned);
  assign abs_b    = div_abs(bus.divisor, bus.is_unsigned);
  assign div_zero = (bus.divisor == 32'd0);

`ifdef DIV_EARLY_OUT_EN
  assign early = !div_zero && (abs_b > abs_a);
`else
  assign early = 1'b0;
`endif

  assign accept = bus.in_valid && bus.in_ready;

  div_restore_step u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_nxt),
    .q_o (q_nxt)
  );

  // Divide-by-zero results bypass sign correction: q is all ones and r is
  // the raw dividend regardless of signedness.
  assign q_fix = (neg_q_q && !dz_q) ? (~q_q + 32'd1) : q_q;
  assign r_fix = (neg_r_q && !dz_q) ? (~r_q + 32'd1) : r_q;

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        // Divide-by-zero and early-out both go through FIX so that the
        // result is registered there and out_valid rises two cycles after accept.
        DIV_IDLE: if (accept) state_d = (div_zero || early) ? DIV_FIX : DIV_CALC;
        DIV_CALC: if (cnt_q == 5'(DIV_STEPS - 1)) state_d = DIV_FIX;
        DIV_FIX:  state_d = DIV_DONE;
        DIV_DONE: if (bus.out_ready) state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      mod_q     <= 1'b0;
      dz_q      <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            d_q     <= abs_b;
            mod_q   <= bus.use_mod;
            tag_q   <= bus.in_tag;
            dz_q    <= div_zero;
            neg_q_q <= !bus.is_unsigned && (bus.dividend[31] ^ bus.divisor[31]);
            neg_r_q <= !bus.is_unsigned && bus.dividend[31];
            if (div_zero) begin
              q_q <= '1;
              r_q <= bus.dividend;
            end else if (early) begin
              q_q <= '0;
              r_q <= abs_a;
            end else begin
              // q doubles as the dividend shift register during CALC.
              q_q <= abs_a;
              r_q <= '0;
            end
          end
        end
        DIV_CALC: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + 5'd1;
        end
        DIV_FIX: begin
          if (!bus.flush) begin
            result_q  <= mod_q ? r_fix : q_fix;
            out_tag_q <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == DIV_IDLE) && !bus.flush;
  assign bus.out_valid = (state_q == DIV_DONE);
  assign bus.busy      = (state_q != DIV_IDLE);
  assign bus.result    = result_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: spec vectors, flush, hold, reset and random ops.
// Latency: expected 34 cycles (2 for divide-by-zero / early-out when DIV_EARLY_OUT_EN is defined).
// Backpressure: exercises out_ready held low in DONE and flush with/without out_ready.
module tb_div_seq_ctrl;
  import div_seq_ctrl_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  div_seq_ctrl_if #(.TAG_W(5)) bus();

  div_seq_ctrl #(.TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model built on the simulator's own division operators.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic uns, input logic md);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (uns) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return md ? r : q;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic uns);
    if (!uns && v[31]) return 32'd0 - v;
    return v;
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic uns);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(b, uns) > mag(a, uns)) return 2;
`endif
    return 34;
  endfunction

  // Drive one request at a negedge; accept happens at the following posedge.
  task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                           input logic uns, input logic md, input logic [4:0] tag);
    bus.dividend    = a;
    bus.divisor     = b;
    bus.is_unsigned = uns;
    bus.use_mod     = md;
    bus.in_tag      = tag;
    bus.in_valid    = 1'b1;
  endtask

  // Issue, wait for the result, score it and consume it.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic uns, input logic md, input logic [4:0] tag,
                       input logic [31:0] exp_res);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready_idle: got %b need 1", nm, bus.in_ready);
    end
    drive_req(a, b, uns, md, tag);
    e.res = exp_res; e.tag = tag; e.lat = exp_lat(a, b, uns);
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Scramble operands after accept; the divider must ignore them.
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    bus.use_mod  = 1'($urandom);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      seen = bus.out_valid;
    end
    e = sb.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no out_valid within 200 cycles", nm);
    end else begin
      if (cyc != e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d need %0d", nm, cyc, e.lat);
      end
      n_checks++;
      if (bus.result !== e.res) begin
        n_fail++;
        $display("FAIL %s result: got %h need %h", nm, bus.result, e.res);
      end
      n_checks++;
      if (bus.out_tag !== e.tag) begin
        n_fail++;
        $display("FAIL %s out_tag: got %h need %h", nm, bus.out_tag, e.tag);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    bus.flush = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.dividend = 32'd100; bus.divisor = 32'd7; bus.is_unsigned = 1'b0;
    bus.use_mod = 1'b0; bus.in_tag = 5'd3;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got out_valid=%b busy=%b need 0 0", bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.result !== 32'd0 || bus.out_tag !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data: got result=%h tag=%h need 0 0", bus.result, bus.out_tag);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b need 1", bus.in_ready);
    end
  endtask

  task automatic test_vectors;
    do_op("s7div2",   32'd7, 32'd2, 1'b0, 1'b0, 5'd1, 32'd3);
    do_op("s7mod2",   32'd7, 32'd2, 1'b0, 1'b1, 5'd2, 32'd1);
    do_op("sm7div2",  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 5'd3, 32'hFFFF_FFFD);
    do_op("sm7mod2",  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 5'd4, 32'hFFFF_FFFF);
    do_op("umaxdiv2", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 5'd5, 32'h7FFF_FFFF);
    do_op("umaxmod2", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 5'd6, 32'd1);
    do_op("ovf_div",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd7, 32'h8000_0000);
    do_op("ovf_mod",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd8, 32'd0);
    do_op("dz_div",   32'h1234, 32'd0, 1'b0, 1'b0, 5'd9, 32'hFFFF_FFFF);
    do_op("dz_mod",   32'h1234, 32'd0, 1'b0, 1'b1, 5'd10, 32'h1234);
    do_op("s3div10",  32'd3, 32'd10, 1'b0, 1'b0, 5'd11, 32'd0);
    do_op("sm3mod10", 32'hFFFF_FFFD, 32'd10, 1'b0, 1'b1, 5'd12, 32'hFFFF_FFFD);
  endtask

  task automatic test_flush;
    @(negedge clk);
    drive_req(32'd1000, 32'd7, 1'b0, 1'b0, 5'd20);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    // Flush in CALC cycle 10 while a new request is already presented.
    bus.flush = 1'b1;
    drive_req(32'd9, 32'd3, 1'b0, 1'b0, 5'd21);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b need 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: got busy=%b out_valid=%b need 0 0", bus.busy, bus.out_valid);
    end
    do_op("after_flush", 32'd9, 32'd3, 1'b0, 1'b0, 5'd21, 32'd3);
  endtask

  task automatic test_hold;
    logic [31:0] r0;
    logic [4:0]  t0;
    int          cyc;
    @(negedge clk);
    drive_req(32'd100, 32'd9, 1'b1, 1'b1, 5'd17);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_timeout: no out_valid within 200 cycles");
    end
    r0 = bus.result;
    t0 = bus.out_tag;
    n_checks++;
    if (r0 !== 32'd1 || t0 !== 5'd17) begin
      n_fail++;
      $display("FAIL hold_value: got %h/%h need 00000001/11", r0, t0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.result !== r0 || bus.out_tag !== t0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got v=%b rdy=%b res=%h tag=%h need 1 0 %h %h",
                 i, bus.out_valid, bus.in_ready, bus.result, bus.out_tag, r0, t0);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got rdy=%b v=%b need 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_flush_done;
    exp_t e;
    int   cyc;
    @(negedge clk);
    drive_req(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 5'd25);
    e.res = model(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0); e.tag = 5'd25; e.lat = 34;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.result !== e.res || bus.out_tag !== e.tag) begin
      n_fail++;
      $display("FAIL flush_done_value: got %h/%h need %h/%h", bus.result, bus.out_tag, e.res, e.tag);
    end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done_idle: got v=%b busy=%b rdy=%b need 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    drive_req(32'd12345, 32'd11, 1'b1, 1'b0, 5'd30);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.result !== 32'd0 || bus.out_tag !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_midop: got busy=%b v=%b res=%h tag=%h need 0 0 0 0",
               bus.busy, bus.out_valid, bus.result, bus.out_tag);
    end
    reset = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got out_valid=%b need 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic        uns, md;
    for (int i = 0; i < 16; i++) begin
      a   = $urandom;
      uns = 1'($urandom);
      md  = 1'($urandom);
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 15));
        1: b = 32'd0 - 32'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = (i == 5) ? 32'd0 : a >> $urandom_range(1, 31);
      endcase
      if (i == 3) a = 32'd5;
      do_op("rand", a, b, uns, md, 5'(i), model(a, b, uns, md));
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.is_unsigned = 1'b0; bus.use_mod = 1'b0;
    bus.dividend = '0; bus.divisor = '0; bus.in_tag = '0;
    test_reset();
    test_vectors();
    test_flush();
    test_hold();
    test_flush_done();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
